// File: rtl/param_mod_counter_pkg.sv
// Shared constants and helpers for the parametrised modulo-N counter.
// Optional build macro used by this slice: PARAM_MOD_COUNTER_DUTY50_EN.
package param_mod_counter_pkg;

    localparam int MAX_WIDTH = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wide enough to hold 2^MAX_WIDTH; callers slice down to WIDTH+1 bits.
    typedef logic [MAX_WIDTH:0] mod_t;

    localparam mod_t MOD_ZERO = {(MAX_WIDTH+1){1'b0}};
    localparam mod_t MOD_ONE  = {{MAX_WIDTH{1'b0}}, 1'b1};

    function automatic mod_t mod_effective(input mod_t mod_val, input int width);
        mod_t m;
        if (mod_val == MOD_ZERO) begin
            m = MOD_ONE << width;
        end else begin
            m = mod_val;
        end
        return m;
    endfunction

    function automatic mod_t sat_load(input mod_t load_val, input mod_t m);
        mod_t v;
        if (load_val >= m) begin
            v = m - MOD_ONE;
        end else begin
            v = load_val;
        end
        return v;
    endfunction

endpackage

// File: rtl/param_mod_counter_div_out.sv
// Divided-output generator: one-cycle pulse after terminal count, or a
// 50% duty square wave when PARAM_MOD_COUNTER_DUTY50_EN is defined.
module mod_div_out
    import param_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tc,
    output logic div_out
);

    logic div_q;
    logic div_d;

    // Next-state of the divided output.
    always_comb begin
        div_d = 1'b0;
`ifdef PARAM_MOD_COUNTER_DUTY50_EN
        if (tc) begin
            div_d = ~div_q;
        end else begin
            div_d = div_q;
        end
`else
        div_d = tc;
`endif
    end

    // Divided-output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign div_out = div_q;

endmodule

// File: rtl/param_mod_counter.sv
// Parametrised modulo-N up/down counter with runtime modulus, load,
// terminal-count flag and divided output (see PARAM_MOD_COUNTER_DUTY50_EN).
module param_mod_counter
    import param_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_MOD = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out
);

    localparam int               MW          = WIDTH + 1;
    localparam logic [WIDTH:0]   RESET_MOD_W = MW'(RESET_MOD);
    localparam logic [WIDTH:0]   M_ONE       = MW'(1);
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO      = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   mod_q, mod_d;

    logic [WIDTH:0]   cnt_ext_s;
    logic [WIDTH:0]   m_minus1_s;
    logic [WIDTH:0]   term_s;
    mod_t             mod_eff_s;
    mod_t             load_sat_s;
    logic             tc_s;

    assign cnt_ext_s  = {1'b0, count_q};
    assign m_minus1_s = mod_q - M_ONE;
    assign term_s     = (up == DIR_UP) ? m_minus1_s : {MW{1'b0}};
    assign mod_eff_s  = mod_effective(mod_t'(mod_val), WIDTH);
    assign load_sat_s = sat_load(mod_t'(load_val), mod_t'(mod_q));

    // Out-of-range counts (after a modulus shrink) never flag terminal.
    assign tc_s = reset & en & (cnt_ext_s < mod_q) & (cnt_ext_s == term_s);

    // Next count and modulus; load has priority over enable.
    always_comb begin
        count_d = count_q;
        mod_d   = mod_q;
        if (mod_wr) begin
            mod_d = mod_eff_s[WIDTH:0];
        end else begin
            mod_d = mod_q;
        end
        if (load) begin
            count_d = load_sat_s[WIDTH-1:0];
        end else if (en) begin
            if (up == DIR_UP) begin
                if (cnt_ext_s >= m_minus1_s) begin
                    count_d = C_ZERO;
                end else begin
                    count_d = count_q + C_ONE;
                end
            end else begin
                if ((count_q == C_ZERO) || (cnt_ext_s >= mod_q)) begin
                    count_d = m_minus1_s[WIDTH-1:0];
                end else begin
                    count_d = count_q - C_ONE;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter and modulus registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= C_ZERO;
            mod_q   <= RESET_MOD_W;
        end else begin
            count_q <= count_d;
            mod_q   <= mod_d;
        end
    end

    mod_div_out u_div_out (
        .clk     (clk),
        .reset   (reset),
        .tc      (tc_s),
        .div_out (div_out)
    );

    assign count = count_q;
    assign tc    = tc_s;

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed self-checking bench for param_mod_counter (WIDTH=4, RESET_MOD=10).
module tb_param_mod_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mod_wr;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             div_out;

    int checks = 0;
    int errors = 0;

    param_mod_counter #(.WIDTH(WIDTH), .RESET_MOD(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_val  (mod_val),
        .count    (count),
        .tc       (tc),
        .div_out  (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int pulses;
        int exp_div;
        reset = 1'b0; en = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd5;
        mod_wr = 1'b1; mod_val = 4'd3;
        #1;
        chk("tc_gated_in_reset", int'(tc), 0);
        tick();
        chk("reset_count", int'(count), 0);
        chk("reset_div", int'(div_out), 0);
        load = 1'b0; mod_wr = 1'b0; up = 1'b1;
        tick();
        chk("reset_holds_count", int'(count), 0);

        // Up count with reset modulus 10.
        reset = 1'b1; en = 1'b1; up = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("up_count", int'(count), i);
            chk("up_tc", int'(tc), (i == 9) ? 1 : 0);
            tick();
            chk("up_div", int'(div_out), (i == 9) ? 1 : 0);
        end
        chk("up_wrap", int'(count), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(div_out);
        end
        chk("div_pulses_per_10", pulses, 1);

        // Down count from reset, then reverse direction at 5.
        reset = 1'b0;
        tick();
        reset = 1'b1; up = 1'b0;
        #1;
        chk("down_tc_at_0", int'(tc), 1);
        for (int v = 9; v >= 5; v--) begin
            tick();
            chk("down_count", int'(count), v);
            chk("down_tc", int'(tc), 0);
        end
        up = 1'b1;
        tick();
        chk("dir_change", int'(count), 6);

        // Modulus shrink below current count.
        tick();
        chk("pre_shrink", int'(count), 7);
        en = 1'b0; mod_wr = 1'b1; mod_val = 4'd5;
        #1;
        chk("tc_en0", int'(tc), 0);
        tick();
        mod_wr = 1'b0;
        chk("mod_wr_keeps_count", int'(count), 7);
        en = 1'b1;
        #1;
        chk("oor_no_tc", int'(tc), 0);
        tick();
        chk("oor_recover_up", int'(count), 0);
        for (int i = 0; i < 5; i++) begin
            chk("m5_count", int'(count), i);
            chk("m5_tc", int'(tc), (i == 4) ? 1 : 0);
            tick();
        end
        chk("m5_wrap", int'(count), 0);

        // mod_val=0 selects the full 2^WIDTH range.
        en = 1'b0; mod_wr = 1'b1; mod_val = 4'd0;
        tick();
        mod_wr = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("m16_count", int'(count), i);
            chk("m16_tc", int'(tc), (i == 15) ? 1 : 0);
            tick();
        end
        chk("m16_wrap", int'(count), 0);

        // Load saturation and priority.
        en = 1'b0; mod_wr = 1'b1; mod_val = 4'd10;
        tick();
        mod_wr = 1'b0; load = 1'b1; load_val = 4'd12;
        tick();
        chk("load_sat", int'(count), 9);
        load_val = 4'd3; en = 1'b1; up = 1'b1;
        #1;
        chk("tc_preload", int'(tc), 1);
        tick();
        chk("load_beats_en", int'(count), 3);
        chk("div_after_load_edge", int'(div_out), 1);
        reset = 1'b0; load_val = 4'd5;
        tick();
        chk("reset_beats_load", int'(count), 0);
        reset = 1'b1; load = 1'b0;

        // Down-mode out-of-range recovery goes to M-1 without tc.
        en = 1'b0; mod_wr = 1'b1; mod_val = 4'd0;
        tick();
        mod_wr = 1'b0; load = 1'b1; load_val = 4'd12;
        tick();
        load = 1'b0; mod_wr = 1'b1; mod_val = 4'd5;
        tick();
        mod_wr = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        chk("oor_down_no_tc", int'(tc), 0);
        tick();
        chk("oor_recover_down", int'(count), 4);

        // Modulus 1: count pinned to 0, tc follows en.
        en = 1'b0; mod_wr = 1'b1; mod_val = 4'd1;
        tick();
        mod_wr = 1'b0;
        chk("m1_load_path", int'(count), 4);
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        chk("m1_load_sat0", int'(count), 0);
        en = 1'b1; up = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("m1_tc", int'(tc), 1);
            tick();
            chk("m1_count", int'(count), 0);
        end
        en = 1'b0;
        #1;
        chk("m1_tc_en0", int'(tc), 0);
        en = 1'b1; up = 1'b0;
        #1;
        chk("m1_tc_down", int'(tc), 1);
        tick();
        chk("m1_count_down", int'(count), 0);

`ifdef PARAM_MOD_COUNTER_DUTY50_EN
        // Square wave: M=4 gives 4 high, 4 low.
        reset = 1'b0;
        tick();
        reset = 1'b1; en = 1'b0; mod_wr = 1'b1; mod_val = 4'd4;
        tick();
        mod_wr = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        exp_div = 0;
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 3) exp_div = 1 - exp_div;
            tick();
            chk("duty50_div", int'(div_out), exp_div);
        end
        tick();
        tick();
        tick();
        tick();
        chk("duty50_high", int'(div_out), 1);
        reset = 1'b0;
        tick();
        chk("duty50_reset", int'(div_out), 0);
        reset = 1'b1;
`else
        // Pulse mode: M=4 gives one pulse every 4 enabled cycles.
        reset = 1'b0;
        tick();
        reset = 1'b1; en = 1'b0; mod_wr = 1'b1; mod_val = 4'd4;
        tick();
        mod_wr = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        exp_div = 0;
        for (int i = 0; i < 12; i++) begin
            exp_div = ((i % 4) == 3) ? 1 : 0;
            tick();
            chk("pulse_div", int'(div_out), exp_div);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_mod_counter.md
Name: param_mod_counter

Overview:
Parametrised synchronous modulo-N counter and clock-enable divider. It is the successor to the fixed 3-bit ripple/modulo counters used on the board LEDs.
- Adds generic width, a runtime modulus, up/down counting, parallel load, count enable, terminal-count flag and a registered divided output.
- Intended uses: LED demo tops, and as the common tick generator for debouncers and display multiplexers.

Parameters:
WIDTH, 4, counter width in bits (2..16)
RESET_MOD, 10, modulus used after reset until mod_wr is pulsed (2..2^WIDTH)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous active-low reset; sampled on rising edge of clk
en  input  1  count enable; one step per clk edge while high
up  input  1  direction: 1 = count up, 0 = count down
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded when load=1
mod_wr  input  1  modulus write strobe
mod_val  input  WIDTH  new modulus; 0 means 2^WIDTH
count  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational: en & (count == terminal)
div_out  output  1  registered divided output

Behaviour:
Reset
- The interface is fixed: one clock; reset is synchronous and active-low.
- When reset=0 at a clk edge: count=0, modulus register=RESET_MOD, div_out=0.
- tc=0 during reset, because it is gated internally with reset.
- Reset overrides load, mod_wr and en.

Modulus register M
- Width is WIDTH+1 bits so that 2^WIDTH is representable.
- mod_val=0 → M=2^WIDTH. mod_val=1 → M=1, count is held at 0.
- mod_wr writes M on the edge. It does not change count on that edge.

Terminal value
- Up mode: M-1. Down mode: 0.

Priority per edge (highest first): reset > load > en.
- load=1: count <= min(load_val, M-1). A value out of range saturates to M-1. A load edge does not step the count, and tc on that cycle still reflects the pre-load count.
- en=1, up=1: count==M-1 or count>=M → count <= 0; otherwise count+1.
- en=1, up=0: count==0 → count <= M-1; count>=M → count <= M-1; otherwise count-1.
- en=0: count holds; tc=0.

Other rules
- Changing direction mid-run takes effect on the next enabled edge. There is no extra-cycle penalty.
- tc asserts only on the in-range terminal value. The out-of-range recovery step (after a modulus shrink) does not assert tc.
- M=1: tc=en on every cycle; count stays 0.
- Arithmetic is done WIDTH+1 bits wide. count never exceeds 2^WIDTH-1. No wrap via overflow is permitted.

div_out (default)
- On each edge, div_out <= tc. This gives a one-cycle pulse, one clk after the terminal, once every M enabled cycles.
- Latency from terminal count to div_out: 1 cycle.

Optional Feature:
Macro: PARAM_MOD_COUNTER_DUTY50_EN
- Defined: div_out toggles on each edge where tc=1. The result is a square wave of period 2*M enabled cycles and 50% duty.
- load does not affect the toggle phase; reset clears it to 0.
- Not defined: single-cycle pulse behaviour as described above; the toggle flop is absent.

Decomposition:
Shared package param_mod_counter_pkg:
- DIR_UP/DIR_DOWN constants.
- Width-clamp function mod_effective(mod_val, WIDTH) returning the WIDTH+1-bit M.
- Saturation function sat_load(load_val, M).

Sub-module mod_div_out:
- Takes clk, reset, tc; produces div_out.
- Contains the pulse/toggle generation and the DUTY50 ifdef.
- The counter core stays in param_mod_counter.

Test Plan:
1. Reset then en=1, up=1, WIDTH=4, RESET_MOD=10 → count 0..9,0. tc high when count=9. div_out high one cycle later; its period is 10 cycles.
2. up=0 from reset, en=1 → count 0,9,8,…,1,0. tc at count=0. Toggle up=1 at count=5 → next edge count=6.
3. count=7, mod_wr with mod_val=5, up=1 → next edge count=0 with tc=0. Subsequent sequence 0..4. Then mod_val=0 → counts 0..15.
4. load=1, load_val=12 with M=10 → count=9. Simultaneous load and en → load wins and count does not step. Reset=0 asserted together with load → count=0.
5. mod_val=1, en=1 → count stays 0 and tc=1 every cycle. en=0 → tc=0.
6. With PARAM_MOD_COUNTER_DUTY50_EN defined, M=4, en=1 continuously → div_out is 4 cycles high, 4 cycles low. Reset mid-high → div_out=0 next edge.
